// File: rtl/overcooked_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : overcooked_pkg
//  Description : Constants and types shared by the main-to-player state frame
//                link: game-state codes, packet geometry, byte offsets inside
//                the packet and the state encodings of the frame sequencer and
//                the bit serialiser.
//  Revision    : 1.0 - initial release
// ============================================================================
package overcooked_pkg;

  // Game-state codes carried in packet byte 1
  localparam logic [2:0] WELCOME    = 3'd0;
  localparam logic [2:0] TEAM_ENTRY = 3'd1;
  localparam logic [2:0] PLAYING    = 3'd2;
  localparam logic [2:0] PAUSED     = 3'd3;
  localparam logic [2:0] FINISH     = 3'd4;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 68;

  localparam int GRID_ROWS  = 8;
  localparam int GRID_COLS  = 13;
  localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;
  // Two 4-bit cells share one packet byte
  localparam int GRID_BYTES = GRID_CELLS / 2;

  localparam logic [6:0] OFS_TEAM = 7'd2;
  localparam logic [6:0] OFS_GRID = 7'd15;
  localparam logic [6:0] OFS_CSUM = 7'd67;

  // Frame sequencer: waits for a frame, presents a byte, waits for it to go out
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_LOAD = 2'd1,
    FS_SEND = 2'd2
  } frame_state_t;

  // Bit serialiser line states
  typedef enum logic [2:0] {
    BS_IDLE   = 3'd0,
    BS_START  = 3'd1,
    BS_DATA   = 3'd2,
    BS_PARITY = 3'd3,
    BS_STOP   = 3'd4
  } bit_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : Single-byte UART serialiser, LSB first, idle-high line.
//                A byte is accepted when i_valid and o_ready are both high;
//                the line then carries start, 8 data bits, optional even
//                parity and one stop bit, each CLKS_PER_BIT cycles long.
//                o_done is high in the last cycle of the stop bit so the
//                feeder can present the next byte without an extra gap.
//  Build option: STATE_FRAME_TX_PARITY_EN - insert an even-parity bit
//                between the last data bit and the stop bit.
//  Ports       : clk, reset (sync, active-high)
//                i_data[7:0], i_valid -> byte handshake in
//                o_ready                 serialiser idle, can accept a byte
//                o_done                  last cycle of the stop bit
//                o_tx                    registered serial line
//  Parameter   : CLKS_PER_BIT (>= 4) clk cycles per bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 565
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_tx
);
  import overcooked_pkg::*;

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  bit_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_data;
  logic             r_tx;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_LAST);
  assign o_ready   = (r_state == BS_IDLE);
  assign o_done    = (r_state == BS_STOP) && w_bit_end;
  assign o_tx      = r_tx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BS_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
    end else begin
      if (r_state != BS_IDLE) begin
        r_cnt <= w_bit_end ? '0 : r_cnt + CNT_W'(1);
      end
      case (r_state)
        BS_IDLE: begin
          if (i_valid) begin
            r_data  <= i_data;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= BS_START;
          end
        end
        BS_START: begin
          if (w_bit_end) begin
            r_tx    <= r_data[0];
            r_state <= BS_DATA;
          end
        end
        BS_DATA: begin
          if (w_bit_end) begin
            if (r_bit == 3'd7) begin
`ifdef STATE_FRAME_TX_PARITY_EN
              r_tx    <= ^r_data;
              r_state <= BS_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= BS_STOP;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_data[r_bit + 3'd1];
            end
          end
        end
        BS_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= BS_STOP;
          end
        end
        BS_STOP: begin
          if (w_bit_end) begin
            r_state <= BS_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= BS_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/state_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : state_frame_tx
//  Description : Transmit side of the main-to-player link. On each falling
//                edge of vsync (while idle) the game controller outputs are
//                snapshotted and sent as a 68-byte packet: sync byte, state,
//                team, timer, points, orders, time grid, object grid and an
//                8-bit additive checksum over bytes 1..66.
//  Build option: STATE_FRAME_TX_PARITY_EN - even parity bit per byte
//                (handled in uart_tx_byte; packet contents unchanged).
//  Ports       : clk, reset (sync, active-high)
//                vsync            async frame strobe, falling edge = request
//                game_state[2:0], team_name[2:0][7:0], time_left[7:0],
//                point_total[9:0], orders[3:0], order_times[3:0][4:0],
//                time_grid[3:0][3:0], object_grid[7:0][12:0][3:0]
//                tx               serial line, idle high
//                busy             snapshot capture until last stop bit ends
//                frame_dropped    1-cycle pulse on a request while busy
//  Parameters  : CLKS_PER_BIT (>= 4), SYNC_BYTE
//  Revision    : 1.0 - initial release
// ============================================================================
module state_frame_tx #(
  parameter int         CLKS_PER_BIT = 565,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic [2:0]             game_state,
  input  logic [2:0][7:0]        team_name,
  input  logic [7:0]             time_left,
  input  logic [9:0]             point_total,
  input  logic [3:0]             orders,
  input  logic [3:0][4:0]        order_times,
  input  logic [3:0][3:0]        time_grid,
  input  logic [7:0][12:0][3:0]  object_grid,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_dropped
);
  import overcooked_pkg::*;

  // vsync synchroniser and edge history
  logic r_vs_s1, r_vs_s2, r_vs_hist;
  logic w_fall;

  frame_state_t r_fstate;
  logic [6:0]   r_idx;
  logic [7:0]   r_csum;
  logic         r_busy;
  logic         r_dropped;

  // Snapshot
  logic [2:0]                  r_game_state;
  logic [2:0][7:0]             r_team;
  logic [7:0]                  r_time_left;
  logic [9:0]                  r_points;
  logic [3:0]                  r_orders;
  logic [3:0][4:0]             r_order_times;
  logic [3:0][3:0]             r_time_grid;
  // Cell i = row*13+col sits at bits [4i+3:4i] of the packed grid, so the
  // grid viewed as bytes is already in packet order: byte j = {cell 2j+1, cell 2j}.
  logic [GRID_BYTES-1:0][7:0]  r_grid;

  logic [7:0] w_byte;
  logic [5:0] w_gj;
  logic       w_valid, w_ready, w_done, w_tx;

  assign w_fall  = r_vs_hist & ~r_vs_s2;
  assign w_valid = (r_fstate == FS_LOAD);
  assign w_gj    = 6'(r_idx - OFS_GRID);

  assign tx            = w_tx;
  assign busy          = r_busy;
  assign frame_dropped = r_dropped;

  // Byte selector for the current packet index
  always_comb begin
    w_byte = 8'h00;
    if ((r_idx >= OFS_GRID) && (r_idx < OFS_CSUM)) begin
      w_byte = r_grid[w_gj];
    end else begin
      case (r_idx)
        7'd0:                 w_byte = SYNC_BYTE;
        7'd1:                 w_byte = {5'b0, r_game_state};
        OFS_TEAM:             w_byte = r_team[2];
        OFS_TEAM + 7'd1:      w_byte = r_team[1];
        OFS_TEAM + 7'd2:      w_byte = r_team[0];
        7'd5:                 w_byte = r_time_left;
        7'd6:                 w_byte = {6'b0, r_points[9:8]};
        7'd7:                 w_byte = r_points[7:0];
        7'd8:                 w_byte = {4'b0, r_orders};
        7'd9:                 w_byte = {3'b0, r_order_times[0]};
        7'd10:                w_byte = {3'b0, r_order_times[1]};
        7'd11:                w_byte = {3'b0, r_order_times[2]};
        7'd12:                w_byte = {3'b0, r_order_times[3]};
        7'd13:                w_byte = {r_time_grid[1], r_time_grid[0]};
        7'd14:                w_byte = {r_time_grid[3], r_time_grid[2]};
        OFS_CSUM:             w_byte = r_csum;
        default:              w_byte = 8'h00;
      endcase
    end
  end

  // Snapshot is held between accepted requests; no reset needed on data.
  always_ff @(posedge clk) begin
    if ((r_fstate == FS_IDLE) && w_fall) begin
      r_game_state  <= game_state;
      r_team        <= team_name;
      r_time_left   <= time_left;
      r_points      <= point_total;
      r_orders      <= orders;
      r_order_times <= order_times;
      r_time_grid   <= time_grid;
      r_grid        <= object_grid;
    end
  end

  // Frame sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_s1   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_vs_hist <= 1'b0;
      r_fstate  <= FS_IDLE;
      r_idx     <= '0;
      r_csum    <= '0;
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_vs_s1   <= vsync;
      r_vs_s2   <= r_vs_s1;
      r_vs_hist <= r_vs_s2;
      r_dropped <= w_fall && (r_fstate != FS_IDLE);
      case (r_fstate)
        FS_IDLE: begin
          if (w_fall) begin
            r_fstate <= FS_LOAD;
            r_idx    <= '0;
            r_csum   <= '0;
            r_busy   <= 1'b1;
          end
        end
        FS_LOAD: begin
          if (w_ready) begin
            r_fstate <= FS_SEND;
            // Sync byte and the checksum slot itself are not summed
            if ((r_idx != 7'd0) && (r_idx != OFS_CSUM)) begin
              r_csum <= r_csum + w_byte;
            end
          end
        end
        FS_SEND: begin
          if (w_done) begin
            if (r_idx == OFS_CSUM) begin
              r_fstate <= FS_IDLE;
              r_busy   <= 1'b0;
            end else begin
              r_idx    <= r_idx + 7'd1;
              r_fstate <= FS_LOAD;
            end
          end
        end
        default: begin
          r_fstate <= FS_IDLE;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk     (clk),
    .reset   (reset),
    .i_data  (w_byte),
    .i_valid (w_valid),
    .o_ready (w_ready),
    .o_done  (w_done),
    .o_tx    (w_tx)
  );

endmodule
`default_nettype wire

// File: tb/tb_state_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_frame_tx
//  Description : Self-checking bench for state_frame_tx. A reference model
//                builds each expected packet when a frame is requested and
//                queues its bytes; a UART monitor decodes the line and pops
//                and compares each byte as it arrives.
//  Build option: STATE_FRAME_TX_PARITY_EN - monitor also decodes parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_state_frame_tx;

  localparam int C = 4;
`ifdef STATE_FRAME_TX_PARITY_EN
  localparam int BIT_TIMES = 11;
`else
  localparam int BIT_TIMES = 10;
`endif
  localparam int PKT_CYC = 68 * (BIT_TIMES * C + 1);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  vsync = 1'b1;
  logic [2:0]            gs = '0;
  logic [2:0][7:0]       team = '0;
  logic [7:0]            tl = '0;
  logic [9:0]            pts = '0;
  logic [3:0]            ords = '0;
  logic [3:0][4:0]       ot = '0;
  logic [3:0][3:0]       tg = '0;
  logic [7:0][12:0][3:0] og = '0;
  logic                  tx, busy, frame_dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int drop_cnt = 0;
  int abort_req = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int t_start;

  always #5 clk = ~clk;

  state_frame_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .game_state(gs), .team_name(team), .time_left(tl), .point_total(pts),
    .orders(ords), .order_times(ot), .time_grid(tg), .object_grid(og),
    .tx(tx), .busy(busy), .frame_dropped(frame_dropped)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_log.size()) return rx_log[i];
    return 8'hxx;
  endfunction

  // Reference packet built from the bench's own copy of the inputs
  task automatic push_packet();
    logic [7:0] b [68];
    logic [3:0] cells [104];
    logic [7:0] sum;
    b[0] = 8'hA5;
    b[1] = {5'b0, gs};
    b[2] = team[2];
    b[3] = team[1];
    b[4] = team[0];
    b[5] = tl;
    b[6] = {6'b0, pts[9:8]};
    b[7] = pts[7:0];
    b[8] = {4'b0, ords};
    for (int i = 0; i < 4; i++) b[9+i] = {3'b0, ot[i]};
    b[13] = {tg[1], tg[0]};
    b[14] = {tg[3], tg[2]};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 13; c++) cells[r*13+c] = og[r][c];
    for (int j = 0; j < 52; j++) b[15+j] = {cells[2*j+1], cells[2*j]};
    sum = 8'h00;
    for (int i = 1; i <= 66; i++) sum = sum + b[i];
    b[67] = sum;
    for (int i = 0; i < 68; i++) exp_q.push_back(b[i]);
  endtask

  task automatic randomize_inputs();
    gs   = 3'($urandom);
    team = 24'($urandom);
    tl   = 8'($urandom);
    pts  = 10'($urandom);
    ords = 4'($urandom);
    for (int i = 0; i < 4; i++) ot[i] = 5'($urandom);
    tg   = 16'($urandom);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 13; c++) og[r][c] = 4'($urandom);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (frame_dropped === 1'b1) drop_cnt++;
  end

  // UART monitor: samples each bit near its centre
  initial begin : monitor
    int abort_seen;
    logic [7:0] data;
    logic par, stopb;
    abort_seen = 0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (C/2) @(negedge clk);
        data = 8'h00;
        for (int b = 0; b < 8; b++) begin
          repeat (C) @(negedge clk);
          data[b] = tx;
        end
`ifdef STATE_FRAME_TX_PARITY_EN
        repeat (C) @(negedge clk);
        par = tx;
`else
        par = ^data;
`endif
        repeat (C) @(negedge clk);
        stopb = tx;
        if (abort_seen != abort_req) begin
          abort_seen = abort_req;
        end else begin
          check_eq("stop_bit", 32'(stopb), 32'd1);
`ifdef STATE_FRAME_TX_PARITY_EN
          check_eq("parity_bit", 32'(par), 32'(^data));
`endif
          if (exp_q.size() == 0) check_eq("unexpected_byte", 32'(data), 32'hFFFF_FFFF);
          else check_eq("rx_byte", 32'(data), 32'(exp_q.pop_front()));
          rx_log.push_back(data);
        end
      end
    end
  end

  // Accepted request from idle: checks capture latency and first start bit
  task automatic start_frame();
    @(negedge clk);
    vsync = 1'b0;
    push_packet();
    @(negedge clk);
    @(negedge clk);
    check_eq("busy_before_capture", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("busy_after_capture", 32'(busy), 32'd1);
    check_eq("tx_in_load", 32'(tx), 32'd1);
    t_start = cyc;
    @(negedge clk);
    check_eq("tx_first_start", 32'(tx), 32'd0);
    vsync = 1'b1;
  endtask

  task automatic wait_frame_end();
    bit done;
    done = 1'b0;
    for (int k = 0; k < PKT_CYC + 200 && !done; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) done = 1'b1;
    end
    if (!done) check_eq("busy_timeout", 32'd0, 32'd1);
    else check_eq("packet_length", 32'(cyc - t_start), 32'(PKT_CYC));
    repeat (2*C) @(negedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    int base, drops;
    bit seen;
    // Reset state
    repeat (4) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_dropped", 32'(frame_dropped), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("idle_tx", 32'(tx), 32'd1);

    // Directed frame, plus a dropped request and input changes mid-packet
    gs = 3'd2; team = 24'h434241; tl = 8'd90; pts = 10'd300; ords = 4'd2;
    base  = rx_log.size();
    drops = drop_cnt;
    start_frame();
    repeat (96) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("drop_pulse_count", 32'(drop_cnt - drops), 32'd1);
    randomize_inputs();
    wait_frame_end();
    check_eq("b0_sync", 32'(rx_at(base+0)), 32'hA5);
    check_eq("b1_state", 32'(rx_at(base+1)), 32'h02);
    check_eq("b2_team", 32'(rx_at(base+2)), 32'h43);
    check_eq("b4_team", 32'(rx_at(base+4)), 32'h41);
    check_eq("b5_time", 32'(rx_at(base+5)), 32'h5A);
    check_eq("b6_pts_hi", 32'(rx_at(base+6)), 32'h01);
    check_eq("b7_pts_lo", 32'(rx_at(base+7)), 32'h2C);
    check_eq("b8_orders", 32'(rx_at(base+8)), 32'h02);
    repeat (200) @(negedge clk);
    check_eq("no_second_packet", 32'(rx_log.size() - base), 32'd68);
    check_eq("idle_after_drop", 32'(busy), 32'd0);
    check_eq("drop_count_final", 32'(drop_cnt - drops), 32'd1);

    // Grid corner cells
    gs = 3'd1; team = 24'h5A5958; tl = 8'd0; pts = 10'h3FF; ords = 4'd0;
    ot = '0; tg = 16'h1234; og = '0;
    og[0][0] = 4'h3; og[0][1] = 4'h7; og[7][12] = 4'hF;
    base = rx_log.size();
    start_frame();
    wait_frame_end();
    check_eq("grid_first_byte", 32'(rx_at(base+15)), 32'h73);
    check_eq("grid_last_byte", 32'(rx_at(base+66)), 32'hF0);
    check_eq("tgrid_byte13", 32'(rx_at(base+13)), 32'h34);

    // Random frames
    for (int n = 0; n < 2; n++) begin
      randomize_inputs();
      start_frame();
      wait_frame_end();
    end
    check_eq("no_spurious_drop", 32'(drop_cnt - drops), 32'd1);

    // Reset in the middle of byte 30
    randomize_inputs();
    base = rx_log.size();
    start_frame();
    seen = 1'b0;
    for (int k = 0; k < 31 * (BIT_TIMES*C + 1) + 100 && !seen; k++) begin
      @(negedge clk);
      if (rx_log.size() >= base + 30) seen = 1'b1;
    end
    check_eq("reached_byte30", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 4*C && !seen; k++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    check_eq("byte30_start", 32'(seen), 32'd1);
    abort_req++;
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_tx_high", 32'(tx), 32'd1);
    check_eq("abort_busy_low", 32'(busy), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (15*C) @(negedge clk);
    check_eq("abort_stays_idle", 32'(busy), 32'd0);
    check_eq("abort_line_idle", 32'(tx), 32'd1);

    // Complete packet after the abort
    randomize_inputs();
    base = rx_log.size();
    start_frame();
    wait_frame_end();
    check_eq("post_abort_bytes", 32'(rx_log.size() - base), 32'd68);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
